mips_mc_ctrl: RTL and testbench

Main control unit for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath selects and enables: register destination, ALU source, register write enable, memory, IR and PC. It also handshakes with a shared instruction/data memory that may insert wait states.

---
 rtl/mips_mc_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Main control unit for the multicycle MIPS datapath.
// Sequences each instruction through fetch, decode, execute, memory and writeback.
// It drives the datapath selects and enables, and handshakes with a shared
// instruction/data memory that may insert wait states.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode, funct         IR fields instr[31:26] and instr[5:0]
//   zero                  ALU zero flag (qualifies the beq PC write)
//   mem_ready             memory completes the current access this cycle
//   mem_req, mem_we       memory request / write
//   iord                  memory address select (0 = PC, 1 = ALUOut)
//   ir_write, pc_en       IR load, PC write enable
//   pc_src                next PC select
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_ctl               ALU operation
//   reg_dst, mem_to_reg   register file destination and writeback source
//   reg_write             register file write enable
//   illegal               one-cycle pulse on an undefined opcode or funct
//   state_o               current state, for debug
module mips_mc_ctrl #(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctl,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXER   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_EXEI   = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_ILL    = 4'd13;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Idle counter value on the last S_IDLE cycle.
  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       funct_ok;
  logic [2:0] funct_alu;

  // R-type funct decode; funct_ok gates the S_EXER path.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    unique case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (idle_cnt_q == HOLD_LAST) begin
          state_d    = S_FETCH;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 4'd1;
        end
      end
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_R:         state_d = funct_ok ? S_EXER : S_ILL;
          OP_ADDI:      state_d = S_EXEI;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILL;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXER:   state_d = S_ALUWB;
      S_EXEI:   state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP, S_ILL: state_d = S_FETCH;
      // Unused codes recover straight into fetch.
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Moore decode; ir_write/pc_en in fetch and pc_en in branch are qualified
  // combinationally so a stalled fetch or untaken branch writes nothing.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = 3'b000;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_ctl   = ALU_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctl   = ALU_ADD;
      end
      S_MEMADR, S_EXEI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctl   = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXER: begin
        alu_src_a = 1'b1;
        alu_ctl   = funct_alu;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      S_ILL:    illegal = 1'b1;
      default:  ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctl;
  logic       reg_dst, mem_to_reg, reg_write, illegal;
  logic [3:0] state_o;
  logic [16:0] outs;

  int checks = 0;
  int errors = 0;

  mips_mc_ctrl #(.RESET_PC_HOLD(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctl    (alu_ctl),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_ctl,
                 reg_dst, mem_to_reg, reg_write, illegal};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: R-type funct -> {valid, alu_ctl}.
  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  // Runs one instruction starting in fetch, with w0 fetch wait cycles and w1 data wait
  // cycles; checks instruction-level totals against the architectural rules.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int w0, input int w1);
    bit is_r, is_ld, is_st, is_mem, legal, wr;
    int base, ncyc, d0, exp_pc;
    logic [2:0] exp_alu;
    bit exp_seen;
    bit plan[64];
    int n_req = 0, n_we = 0, n_wr = 0, n_ir = 0, n_pc = 0, n_ill = 0;
    bit seen_alu = 0;
    logic [2:0] last_alu = '0;
    logic wr_dst = 0, wr_m2r = 0;

    is_r   = (op == 6'b000000) && r_alu(fn)[3];
    is_ld  = (op == 6'b100011);
    is_st  = (op == 6'b101011);
    is_mem = is_ld || is_st;
    legal  = is_r || is_mem || op == 6'b001000 || op == 6'b000100 || op == 6'b000010;
    wr     = is_r || is_ld || op == 6'b001000;
    base   = is_ld ? 5 : (is_r || is_st || op == 6'b001000) ? 4 : 3;
    ncyc   = base + w0 + (is_mem ? w1 : 0);
    exp_pc = 1 + ((op == 6'b000010) ? 1 : 0) + ((op == 6'b000100 && z) ? 1 : 0);
    exp_seen = is_r || is_mem || op == 6'b001000 || op == 6'b000100;
    exp_alu  = is_r ? r_alu(fn)[2:0] : (op == 6'b000100) ? 3'b110 : 3'b010;

    d0 = w0 + 3;
    for (int c = 0; c < 64; c++) begin
      if (c < w0) plan[c] = 1'b0;
      else if (c == w0) plan[c] = 1'b1;
      else if (is_mem && c >= d0 && c < d0 + w1) plan[c] = 1'b0;
      else if (is_mem && c == d0 + w1) plan[c] = 1'b1;
      else plan[c] = 1'($urandom_range(0, 1));
    end

    opcode = op;
    funct  = fn;
    zero   = z;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      mem_ready = plan[c];
      #1;
      if (c == 0) check("instr_start_fetch", 32'(state_o), 32'd1);
      if (mem_req) n_req++;
      if (mem_we) n_we++;
      if (ir_write) n_ir++;
      if (pc_en) n_pc++;
      if (illegal) n_ill++;
      if (reg_write) begin
        n_wr++;
        wr_dst = reg_dst;
        wr_m2r = mem_to_reg;
      end
      if (alu_src_a) begin
        seen_alu = 1;
        last_alu = alu_ctl;
      end
    end
    check("mem_req_cycles", 32'(n_req), 32'(w0 + 1 + (is_mem ? w1 + 1 : 0)));
    check("mem_we_cycles", 32'(n_we), 32'(is_st ? w1 + 1 : 0));
    check("ir_write_cycles", 32'(n_ir), 32'd1);
    check("pc_en_cycles", 32'(n_pc), 32'(exp_pc));
    check("illegal_cycles", 32'(n_ill), 32'(legal ? 0 : 1));
    check("reg_write_cycles", 32'(n_wr), 32'(wr ? 1 : 0));
    check("alu_a_used", 32'(seen_alu), 32'(exp_seen));
    if (exp_seen) check("alu_ctl", 32'(last_alu), 32'(exp_alu));
    if (wr) begin
      check("wb_reg_dst", 32'(wr_dst), 32'(is_r));
      check("wb_mem_to_reg", 32'(wr_m2r), 32'(is_ld));
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    int          len;
    logic [23:0] seq;   // expected state per cycle, one nibble each, first cycle in [3:0]
    logic [2:0]  alu;   // expected alu_ctl in the third cycle
  } vec_t;

  vec_t vecs[12];
  logic [5:0] fn_list[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    vecs[0]  = '{6'b000000, 6'b100000, 1'b0, 4, 24'h008721, 3'b010};
    vecs[1]  = '{6'b000000, 6'b100010, 1'b0, 4, 24'h008721, 3'b110};
    vecs[2]  = '{6'b000000, 6'b100100, 1'b0, 4, 24'h008721, 3'b000};
    vecs[3]  = '{6'b000000, 6'b100101, 1'b0, 4, 24'h008721, 3'b001};
    vecs[4]  = '{6'b000000, 6'b101010, 1'b0, 4, 24'h008721, 3'b111};
    vecs[5]  = '{6'b001000, 6'b000000, 1'b0, 4, 24'h00a921, 3'b010};
    vecs[6]  = '{6'b100011, 6'b000000, 1'b0, 5, 24'h054321, 3'b010};
    vecs[7]  = '{6'b101011, 6'b000000, 1'b0, 4, 24'h006321, 3'b010};
    vecs[8]  = '{6'b000100, 6'b000000, 1'b1, 3, 24'h000b21, 3'b110};
    vecs[9]  = '{6'b000010, 6'b000000, 1'b0, 3, 24'h000c21, 3'b000};
    vecs[10] = '{6'b111111, 6'b000000, 1'b0, 3, 24'h000d21, 3'b000};
    vecs[11] = '{6'b000000, 6'b000001, 1'b0, 3, 24'h000d21, 3'b000};

    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = '0;
    funct = '0;
    zero = 1'b0;

    // Reset and idle hold.
    #12;
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_state", 32'(state_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_state", 32'(state_o), 32'd0);
    check("idle_outs", 32'(outs), 32'd0);
    @(negedge clk);
    #1;
    check("first_fetch_state", 32'(state_o), 32'd1);
    check("first_fetch_req", 32'(mem_req), 32'd1);
    check("first_fetch_alub", 32'(alu_src_b), 32'd1);

    // Table of state sequences, memory always ready.
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      funct  = vecs[i].fn;
      zero   = vecs[i].z;
      for (int c = 0; c < vecs[i].len; c++) begin
        logic [3:0] es;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        es = vecs[i].seq[4*c +: 4];
        check($sformatf("vec%0d_state_c%0d", i, c), 32'(state_o), 32'(es));
        check($sformatf("vec%0d_illegal_c%0d", i, c), 32'(illegal), 32'(es == 4'd13));
        if (c == 2) check($sformatf("vec%0d_alu", i), 32'(alu_ctl), 32'(vecs[i].alu));
      end
    end

    // lw with two data wait cycles (7 cycles), beq taken and not taken.
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 2);
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b111111, 6'b000000, 1'b0, 1, 0);
    run_instr(6'b000000, 6'b000001, 1'b0, 0, 0);

    // Randomized instruction stream with random wait states.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      int k;
      k  = $urandom_range(0, 9);
      fn = fn_list[$urandom_range(0, 4)];
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 63));
      case (k)
        5: op = 6'b001000;
        6: op = 6'b100011;
        7: op = 6'b101011;
        8: op = 6'b000100;
        9: op = 6'b000010;
        default: op = 6'b000000;
      endcase
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // sw with reset dropped in the middle of a write wait.
    opcode = 6'b101011;
    funct  = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ready = (c == 0);
      #1;
      if (c == 0) check("sw_rst_fetch", 32'(state_o), 32'd1);
      if (c == 3) check("sw_rst_memwr_we", 32'(mem_we), 32'd1);
      if (c == 4) check("sw_rst_memwr_state", 32'(state_o), 32'd6);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("sw_rst_outs", 32'(outs), 32'd0);
    check("sw_rst_state", 32'(state_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sw_rst_idle", 32'(state_o), 32'd0);
    @(negedge clk);
    #1;
    check("sw_rst_refetch", 32'(state_o), 32'd1);
    check("sw_rst_refetch_iord", 32'(iord), 32'd0);
    check("sw_rst_refetch_req", 32'(mem_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
